pipeline_ctrl_hz: RTL and testbench
===================================

// Module: pipeline_ctrl_hz
// PURPOSE
//  Next-generation 3-stage (IF / EX / MW) pipeline controller. Decodes the EX-stage instruction and
//  pipelines the MW-stage controls. Adds what the first-generation controller lacks: operand
//  forwarding, load-use stall, branch flush with a full condition set, and a memory-ready wait with
//  a timeout. Sits between the instruction register, ALU, data memory and PC logic of the core.
// PARAMETERS
//  RADDR_W     5    register-address width (rs1/rs2/rd)
//  LOAD_FWD    0    1: forward load data from MW in the same cycle; 0: 1-cycle load-use stall
//  MEM_TO_W    8    width of the memory-wait counter
//  MEM_TO_MAX  200  wait cycles before mem_err is set
// PORTS
//  clk          in   1   core clock
//  rst          in   1   reset; asynchronous, active-low
//  inst_ex      in   32  instruction currently in EX (RV32 field layout)
//  zero_flag    in   1   ALU result == 0
//  lt_flag      in   1   ALU signed less-than
//  mem_ready    in   1   data memory completed the MW access this cycle
//  alu_op       out  4   ALU operation, combinational from inst_ex
//  alu_src      out  1   1 = immediate operand B
//  memwq        out  1   MW store enable, registered
//  memrq        out  1   MW load enable, registered
//  regwq        out  1   MW register write enable, registered
//  mem2regq     out  1   MW writeback source is memory, registered
//  rd_mw        out  RADDR_W  MW destination register, registered
//  fwd_a        out  2   operand A source: 00 regfile, 01 MW ALU result, 10 MW load data, 11 WB hold
//  fwd_b        out  2   operand B source, same encoding as fwd_a
//  sel          out  1   branch taken; PC takes the target
//  flush        out  1   kill the IF instruction (becomes a bubble in EX)
//  pc_en        out  1   PC / IF-EX register advance enable
//  stall        out  1   any stall active
//  illegal      out  1   inst_ex opcode is unrecognised (combinational pulse)
//  mem_err      out  1   sticky memory timeout; cleared only by reset
// BEHAVIOUR
//  Reset (rst=0, async)
//   - memwq, memrq, regwq, mem2regq, rd_mw, the WB hold register, the counter and mem_err all go to 0.
//   - Combinational outputs follow from the cleared state.
//  Decode
//   - Opcodes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011.
//   - Any other opcode: all controls 0 and illegal=1.
//   - alu_op keeps the existing {funct7[5],funct3} ALU-control encoding.
//  EX->MW register
//   - pc_en=1: MW captures the decoded controls and rd.
//   - Load-use stall: MW captures a bubble (all controls 0).
//   - Memory stall: MW holds its contents.
//  WB hold
//   - One register {regw, rd} plus the data-select path, captured from MW whenever MW retires.
//   - Source for fwd=11.
//  Forwarding (rd==0 never forwards)
//   - Priority: MW over WB hold.
//   - MW store/ALU match -> 01.
//   - MW load match: 10 if LOAD_FWD=1; else stall and 11 on the next cycle.
//  Load-use stall (LOAD_FWD=0 only)
//   - Trigger: memrq & rd_mw!=0 & rd_mw matches a used rs of inst_ex.
//   - Exactly 1 cycle: pc_en=0, stall=1, bubble into MW.
//  Branch
//   - Condition by funct3: 000 zero, 001 !zero, 100 lt, 101 !lt; any other funct3 -> not taken.
//   - sel = branch & cond & pc_en.
//   - flush = sel, 1-cycle penalty.
//  Memory stall
//   - Trigger: (memrq|memwq) & !mem_ready.
//   - pc_en=0, stall=1; EX and MW hold; counter increments.
//   - Counter clears on mem_ready. Reaching MEM_TO_MAX sets mem_err; the stall continues.
//  Priority: memory stall > load-use stall > branch.
//   - A branch in EX during a stall is evaluated only when EX advances; no flush while pc_en=0.
//  Reset mid-stall: immediate return to reset state; no partial update survives.
// STRUCTURE
//  Package pipeline_ctrl_pkg
//   - opcode localparams, alu_op encodings, fwd_sel_e enum (REGF, MW_ALU, MW_LD, WB_HOLD).
//   - ctrl_t struct {memw, memr, regw, mem2reg}.
//  Sub-module fwd_unit
//   - Combinational rs/rd compare producing fwd_a, fwd_b and the load-use request.
//   - Instantiated once.
//  Decode, pipeline registers and the stall counter stay in this module.
// TESTING
//  1 Reset: drive rst=0 mid-load -> all q outputs 0, mem_err 0, pc_en 1 after release.
//  2 ALU chain: add x5,x1,x2 then sub x6,x5,x3 -> fwd_a=01 on the sub, no stall.
//  3 Load-use: lw x7,0(x1) then add x8,x7,x2 with LOAD_FWD=0:
//    - stall=1 / pc_en=0 for exactly 1 cycle, bubble into MW, then fwd_a=11.
//    - With LOAD_FWD=1: fwd_a=10 and no stall.
//  4 Branch: bne with zero_flag=0 -> sel=1 and flush=1 for 1 cycle.
//    - funct3=010 -> sel=0.
//  5 Memory wait: lw with mem_ready low 3 cycles -> stall=1 for 3 cycles, EX/MW frozen.
//    - Hold low for 200 cycles -> mem_err=1 and stays 1 until rst.
//  6 Branch in EX during a memory stall -> flush only on the cycle mem_ready=1;
//    - x0 as rd never forwards.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared opcodes, ALU-control codes, forwarding selects and MW control bundle
// for the 3-stage pipeline controller.
package pipeline_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // ALU control is {funct7[5], funct3}; memory ops add, branches subtract to compare
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  localparam logic [2:0] BR_EQ = 3'b000;
  localparam logic [2:0] BR_NE = 3'b001;
  localparam logic [2:0] BR_LT = 3'b100;
  localparam logic [2:0] BR_GE = 3'b101;

  typedef enum logic [1:0] {
    REGF    = 2'b00,
    MW_ALU  = 2'b01,
    MW_LD   = 2'b10,
    WB_HOLD = 2'b11
  } fwd_sel_e;

  typedef struct packed {
    logic memw;
    logic memr;
    logic regw;
    logic mem2reg;
  } ctrl_t;

  function automatic logic br_cond(input logic [2:0] funct3, input logic zero, input logic lt);
    case (funct3)
      BR_EQ:   return zero;
      BR_NE:   return !zero;
      BR_LT:   return lt;
      BR_GE:   return !lt;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hz_fwd_unit.sv
// Operand-source selection for EX from the MW stage and the WB hold register,
// plus the load-use stall request when load data cannot be forwarded in time.
module fwd_unit
  import pipeline_ctrl_pkg::*;
#(
  parameter int RADDR_W  = 5,
  parameter int LOAD_FWD = 0
) (
  input  logic [RADDR_W-1:0] rs1,
  input  logic [RADDR_W-1:0] rs2,
  input  logic               use_rs1,
  input  logic               use_rs2,
  input  logic               mw_regw,
  input  logic               mw_memr,
  input  logic [RADDR_W-1:0] mw_rd,
  input  logic               wb_regw,
  input  logic [RADDR_W-1:0] wb_rd,
  output fwd_sel_e           fwd_a,
  output fwd_sel_e           fwd_b,
  output logic               ld_use_req
);

  function automatic fwd_sel_e pick(input logic [RADDR_W-1:0] rs, input logic use_rs);
    if (!use_rs || rs == '0) return REGF;
    // MW outranks the older WB hold; an unforwardable load leaves the regfile path while stalled
    if (mw_regw && mw_rd == rs) begin
      if (!mw_memr)      return MW_ALU;
      if (LOAD_FWD != 0) return MW_LD;
      return REGF;
    end
    if (wb_regw && wb_rd == rs) return WB_HOLD;
    return REGF;
  endfunction

  logic hit_rs1, hit_rs2;

  always_comb begin
    fwd_a      = pick(rs1, use_rs1);
    fwd_b      = pick(rs2, use_rs2);
    hit_rs1    = use_rs1 && (rs1 == mw_rd);
    hit_rs2    = use_rs2 && (rs2 == mw_rd);
    ld_use_req = (LOAD_FWD == 0) && mw_memr && (mw_rd != '0) && (hit_rs1 || hit_rs2);
  end

endmodule

// File: rtl/pipeline_ctrl_hz.sv
// 3-stage (IF/EX/MW) pipeline controller: EX decode, EX->MW control register, WB hold,
// forwarding, load-use and memory-wait stalls with timeout, and branch resolution.
module pipeline_ctrl_hz
  import pipeline_ctrl_pkg::*;
#(
  parameter int RADDR_W    = 5,
  parameter int LOAD_FWD   = 0,
  parameter int MEM_TO_W   = 8,
  parameter int MEM_TO_MAX = 200
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        inst_ex,
  input  logic               zero_flag,
  input  logic               lt_flag,
  input  logic               mem_ready,
  output logic [3:0]         alu_op,
  output logic               alu_src,
  output logic               memwq,
  output logic               memrq,
  output logic               regwq,
  output logic               mem2regq,
  output logic [RADDR_W-1:0] rd_mw,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b,
  output logic               sel,
  output logic               flush,
  output logic               pc_en,
  output logic               stall,
  output logic               illegal,
  output logic               mem_err
);

  localparam logic [MEM_TO_W-1:0] TO_MAX  = MEM_TO_W'(MEM_TO_MAX);
  localparam logic [MEM_TO_W-1:0] TO_LAST = MEM_TO_W'(MEM_TO_MAX - 1);

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic               funct7_b5;
  logic [RADDR_W-1:0] rs1, rs2, rd_ex;
  logic               unused_inst_bits;

  assign opcode           = inst_ex[6:0];
  assign funct3           = inst_ex[14:12];
  assign funct7_b5        = inst_ex[30];
  assign rd_ex            = inst_ex[7 +: RADDR_W];
  assign rs1              = inst_ex[15 +: RADDR_W];
  assign rs2              = inst_ex[20 +: RADDR_W];
  assign unused_inst_bits = ^{inst_ex[31], inst_ex[29:25]};

  ctrl_t dec;
  logic  is_branch, use_rs1, use_rs2;

  always_comb begin
    dec       = '0;
    alu_op    = ALU_ADD;
    alu_src   = 1'b0;
    illegal   = 1'b0;
    is_branch = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    case (opcode)
      OP_R: begin
        dec.regw = 1'b1;
        alu_op   = {funct7_b5, funct3};
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
      end
      OP_I: begin
        dec.regw = 1'b1;
        alu_src  = 1'b1;
        // funct7[5] only distinguishes SRAI from SRLI; elsewhere it is immediate data
        alu_op   = {funct7_b5 & (funct3 == 3'b101), funct3};
        use_rs1  = 1'b1;
      end
      OP_LOAD: begin
        dec.memr    = 1'b1;
        dec.regw    = 1'b1;
        dec.mem2reg = 1'b1;
        alu_src     = 1'b1;
        use_rs1     = 1'b1;
      end
      OP_STORE: begin
        dec.memw = 1'b1;
        alu_src  = 1'b1;
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
      end
      OP_BRANCH: begin
        is_branch = 1'b1;
        alu_op    = ALU_SUB;
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  ctrl_t              mw_q;
  logic               wb_regw;
  logic [RADDR_W-1:0] wb_rd;
  logic [MEM_TO_W-1:0] mem_cnt;
  fwd_sel_e           fwd_a_sel, fwd_b_sel;
  logic               ld_use_req, mem_stall, lu_stall;

  fwd_unit #(.RADDR_W(RADDR_W), .LOAD_FWD(LOAD_FWD)) u_fwd (
    .rs1        (rs1),
    .rs2        (rs2),
    .use_rs1    (use_rs1),
    .use_rs2    (use_rs2),
    .mw_regw    (mw_q.regw),
    .mw_memr    (mw_q.memr),
    .mw_rd      (rd_mw),
    .wb_regw    (wb_regw),
    .wb_rd      (wb_rd),
    .fwd_a      (fwd_a_sel),
    .fwd_b      (fwd_b_sel),
    .ld_use_req (ld_use_req)
  );

  // Memory wait outranks load-use; a branch only resolves on a cycle EX advances
  assign mem_stall = (mw_q.memr | mw_q.memw) & ~mem_ready;
  assign lu_stall  = ld_use_req & ~mem_stall;
  assign pc_en     = ~(mem_stall | lu_stall);
  assign stall     = ~pc_en;
  assign sel       = is_branch & br_cond(funct3, zero_flag, lt_flag) & pc_en;
  assign flush     = sel;
  assign fwd_a     = fwd_a_sel;
  assign fwd_b     = fwd_b_sel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mw_q    <= '0;
      rd_mw   <= '0;
      wb_regw <= 1'b0;
      wb_rd   <= '0;
      mem_cnt <= '0;
      mem_err <= 1'b0;
    end else if (!mem_stall) begin
      wb_regw <= mw_q.regw;
      wb_rd   <= rd_mw;
      mem_cnt <= '0;
      if (lu_stall) begin
        mw_q  <= '0;
        rd_mw <= '0;
      end else begin
        mw_q  <= dec;
        rd_mw <= rd_ex;
      end
    end else begin
      if (mem_cnt != TO_MAX) mem_cnt <= mem_cnt + MEM_TO_W'(1);
      if (mem_cnt == TO_LAST) mem_err <= 1'b1;
    end
  end

  assign memwq    = mw_q.memw;
  assign memrq    = mw_q.memr;
  assign regwq    = mw_q.regw;
  assign mem2regq = mw_q.mem2reg;

endmodule

// File: tb/tb_pipeline_ctrl_hz.sv
// Bench for pipeline_ctrl_hz: two instances (load stall / load forward) share stimulus and
// are compared every cycle against an instruction-level model of the pipeline rules.
module tb_pipeline_ctrl_hz;

  localparam int TO_MAX = 200;

  typedef enum int {K_R, K_I, K_LD, K_ST, K_BR, K_BAD} kind_e;
  typedef struct {
    kind_e k;
    int    rd, rs1, rs2, f3, f7b, badop;
  } ins_t;

  logic        clk, rst;
  logic [31:0] inst_ex;
  logic        zero_flag, lt_flag, mem_ready;

  logic [3:0] alu_op   [2];
  logic       alu_src  [2];
  logic       memwq    [2];
  logic       memrq    [2];
  logic       regwq    [2];
  logic       mem2regq [2];
  logic [4:0] rd_mw    [2];
  logic [1:0] fwd_a    [2];
  logic [1:0] fwd_b    [2];
  logic       sel      [2];
  logic       flush    [2];
  logic       pc_en    [2];
  logic       stall    [2];
  logic       illegal  [2];
  logic       mem_err  [2];

  pipeline_ctrl_hz #(.RADDR_W(5), .LOAD_FWD(0), .MEM_TO_W(8), .MEM_TO_MAX(TO_MAX)) dut0 (
    .clk(clk), .rst(rst), .inst_ex(inst_ex), .zero_flag(zero_flag), .lt_flag(lt_flag),
    .mem_ready(mem_ready), .alu_op(alu_op[0]), .alu_src(alu_src[0]), .memwq(memwq[0]),
    .memrq(memrq[0]), .regwq(regwq[0]), .mem2regq(mem2regq[0]), .rd_mw(rd_mw[0]),
    .fwd_a(fwd_a[0]), .fwd_b(fwd_b[0]), .sel(sel[0]), .flush(flush[0]), .pc_en(pc_en[0]),
    .stall(stall[0]), .illegal(illegal[0]), .mem_err(mem_err[0]));

  pipeline_ctrl_hz #(.RADDR_W(5), .LOAD_FWD(1), .MEM_TO_W(8), .MEM_TO_MAX(TO_MAX)) dut1 (
    .clk(clk), .rst(rst), .inst_ex(inst_ex), .zero_flag(zero_flag), .lt_flag(lt_flag),
    .mem_ready(mem_ready), .alu_op(alu_op[1]), .alu_src(alu_src[1]), .memwq(memwq[1]),
    .memrq(memrq[1]), .regwq(regwq[1]), .mem2regq(mem2regq[1]), .rd_mw(rd_mw[1]),
    .fwd_a(fwd_a[1]), .fwd_b(fwd_b[1]), .sel(sel[1]), .flush(flush[1]), .pc_en(pc_en[1]),
    .stall(stall[1]), .illegal(illegal[1]), .mem_err(mem_err[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass = 0;
  int n_fail = 0;

  // Model: what sits in MW, what was last retired, and the wait timer
  bit m_memw[2], m_memr[2], m_regw[2], m_m2r[2];
  int m_rd[2];
  bit w_regw[2];
  int w_rd[2];
  int m_cnt[2];
  bit m_err[2];
  bit e_ms[2], e_lu[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ins_t mk(input kind_e k, input int rd, input int rs1, input int rs2,
                              input int f3, input int f7b);
    ins_t r;
    r.k = k; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.f3 = f3; r.f7b = f7b; r.badop = 0;
    return r;
  endfunction

  function automatic ins_t mk_rand();
    ins_t r;
    int   op;
    r = mk(kind_e'($urandom_range(0, 5)), $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 1));
    do op = $urandom_range(0, 127);
    while (op == 'h33 || op == 'h13 || op == 'h03 || op == 'h23 || op == 'h63);
    r.badop = op;
    return r;
  endfunction

  function automatic logic [31:0] enc(input ins_t c);
    logic [31:0] w;
    logic [6:0]  op;
    case (c.k)
      K_R:     op = 7'b0110011;
      K_I:     op = 7'b0010011;
      K_LD:    op = 7'b0000011;
      K_ST:    op = 7'b0100011;
      K_BR:    op = 7'b1100011;
      default: op = 7'(c.badop);
    endcase
    w        = $urandom();
    w[6:0]   = op;
    w[11:7]  = 5'(c.rd);
    w[14:12] = 3'(c.f3);
    w[19:15] = 5'(c.rs1);
    w[24:20] = 5'(c.rs2);
    w[30]    = c.f7b[0];
    return w;
  endfunction

  function automatic bit taken(input int f3, input bit z, input bit lt);
    if (f3 == 0) return z;
    if (f3 == 1) return !z;
    if (f3 == 4) return lt;
    if (f3 == 5) return !lt;
    return 0;
  endfunction

  function automatic int fwd_of(input int i, input int rs, input bit used);
    if (!used || rs == 0) return 0;
    if (m_regw[i] && m_rd[i] == rs) return m_memr[i] ? (i == 1 ? 2 : 0) : 1;
    if (w_regw[i] && w_rd[i] == rs) return 3;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_memw[i] = 0; m_memr[i] = 0; m_regw[i] = 0; m_m2r[i] = 0; m_rd[i] = 0;
      w_regw[i] = 0; w_rd[i] = 0; m_cnt[i] = 0; m_err[i] = 0;
    end
  endtask

  task automatic check_all(input ins_t c, input bit z, input bit lt, input bit mr);
    for (int i = 0; i < 2; i++) begin
      bit u1, u2, ms, lu, pe, tk, asrc, ill;
      int fa, fb, aop;
      u1   = (c.k != K_BAD);
      u2   = (c.k == K_R || c.k == K_ST || c.k == K_BR);
      ms   = (m_memr[i] || m_memw[i]) && !mr;
      lu   = (i == 0) && m_memr[i] && m_rd[i] != 0 && !ms &&
             ((u1 && c.rs1 == m_rd[i]) || (u2 && c.rs2 == m_rd[i]));
      pe   = !ms && !lu;
      tk   = (c.k == K_BR) && taken(c.f3, z, lt) && pe;
      fa   = fwd_of(i, c.rs1, u1);
      fb   = fwd_of(i, c.rs2, u2);
      asrc = (c.k == K_I || c.k == K_LD || c.k == K_ST);
      ill  = (c.k == K_BAD);
      case (c.k)
        K_R:     aop = c.f7b * 8 + c.f3;
        K_I:     aop = (c.f3 == 5 ? c.f7b * 8 : 0) + c.f3;
        K_BR:    aop = 8;
        default: aop = 0;
      endcase
      chk($sformatf("d%0d fwd", i), {28'd0, fwd_a[i], fwd_b[i]}, 32'(fa * 4 + fb));
      chk($sformatf("d%0d flow{stall,pc_en,sel,flush}", i),
          {28'd0, stall[i], pc_en[i], sel[i], flush[i]}, {28'd0, !pe, pe, tk, tk});
      chk($sformatf("d%0d decode{alu_op,alu_src,illegal}", i),
          {26'd0, alu_op[i], alu_src[i], illegal[i]}, {26'd0, 4'(aop), asrc, ill});
      chk($sformatf("d%0d mw{memw,memr,regw,mem2reg,rd}", i),
          {23'd0, memwq[i], memrq[i], regwq[i], mem2regq[i], rd_mw[i]},
          {23'd0, m_memw[i], m_memr[i], m_regw[i], m_m2r[i], 5'(m_rd[i])});
      chk($sformatf("d%0d mem_err", i), {31'd0, mem_err[i]}, {31'd0, m_err[i]});
      e_ms[i] = ms;
      e_lu[i] = lu;
    end
  endtask

  task automatic model_update(input ins_t c);
    for (int i = 0; i < 2; i++) begin
      if (e_ms[i]) begin
        if (m_cnt[i] < TO_MAX) m_cnt[i]++;
        if (m_cnt[i] >= TO_MAX) m_err[i] = 1;
      end else begin
        m_cnt[i]  = 0;
        w_regw[i] = m_regw[i];
        w_rd[i]   = m_rd[i];
        if (e_lu[i]) begin
          m_memw[i] = 0; m_memr[i] = 0; m_regw[i] = 0; m_m2r[i] = 0; m_rd[i] = 0;
        end else begin
          m_memw[i] = (c.k == K_ST);
          m_memr[i] = (c.k == K_LD);
          m_regw[i] = (c.k == K_R || c.k == K_I || c.k == K_LD);
          m_m2r[i]  = (c.k == K_LD);
          m_rd[i]   = c.rd;
        end
      end
    end
  endtask

  // One clock: drive at the falling edge, compare, then advance the model at the rising edge
  task automatic cyc(input ins_t c, input bit z, input bit lt, input bit mr);
    inst_ex   = enc(c);
    zero_flag = z;
    lt_flag   = lt;
    mem_ready = mr;
    #1;
    check_all(c, z, lt, mr);
    @(posedge clk);
    model_update(c);
    @(negedge clk);
  endtask

  task automatic reset_mid_cycle();
    #2 rst = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("d%0d rst q", i),
          {27'd0, memwq[i], memrq[i], regwq[i], mem2regq[i], rd_mw[i]}, 32'd0);
      chk($sformatf("d%0d rst mem_err", i), {31'd0, mem_err[i]}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  ins_t nop, ld, add_dep, ld7, add_i, br;

  initial begin
    rst = 1'b0; inst_ex = '0; zero_flag = 0; lt_flag = 0; mem_ready = 1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    nop = mk(K_I, 0, 0, 0, 0, 0);
    cyc(nop, 0, 0, 1);
    cyc(nop, 0, 0, 1);

    // ALU chain: add x5,x1,x2 ; sub x6,x5,x3
    cyc(mk(K_R, 5, 1, 2, 0, 0), 0, 0, 1);
    cyc(mk(K_R, 6, 5, 3, 0, 1), 0, 0, 1);
    cyc(nop, 0, 0, 1);

    // Load-use: lw x7,0(x1) ; add x8,x7,x2 (held in EX while stalled)
    ld7     = mk(K_LD, 7, 1, 0, 2, 0);
    add_dep = mk(K_R, 8, 7, 2, 0, 0);
    cyc(ld7, 0, 0, 1);
    cyc(add_dep, 0, 0, 1);
    cyc(add_dep, 0, 0, 1);
    cyc(nop, 0, 0, 1);

    // Branch conditions
    cyc(mk(K_BR, 3, 1, 2, 1, 0), 0, 0, 1);
    cyc(nop, 0, 0, 1);
    cyc(mk(K_BR, 3, 1, 2, 2, 0), 0, 1, 1);
    cyc(mk(K_BR, 3, 1, 2, 0, 0), 1, 0, 1);
    cyc(mk(K_BR, 3, 1, 2, 4, 0), 0, 1, 1);
    cyc(mk(K_BR, 3, 1, 2, 5, 0), 0, 1, 1);
    cyc(mk(K_I, 4, 1, 9, 5, 1), 0, 0, 1);
    cyc(mk(K_R, 4, 1, 2, 5, 1), 0, 0, 1);

    // Short memory wait: three cycles without mem_ready
    ld    = mk(K_LD, 9, 1, 0, 2, 0);
    add_i = mk(K_R, 10, 1, 2, 0, 0);
    cyc(ld, 0, 0, 1);
    repeat (3) cyc(add_i, 0, 0, 0);
    cyc(add_i, 0, 0, 1);
    cyc(nop, 0, 0, 1);

    // Timeout: 199 cycles stay clean, the 200th sets mem_err, which then sticks
    cyc(ld, 0, 0, 1);
    repeat (TO_MAX) cyc(add_i, 0, 0, 0);
    repeat (3) cyc(add_i, 0, 0, 0);
    cyc(add_i, 0, 0, 1);
    repeat (3) cyc(nop, 0, 0, 1);

    // Reset while a load is waiting on memory
    cyc(ld, 0, 0, 1);
    cyc(nop, 0, 0, 0);
    reset_mid_cycle();
    cyc(nop, 0, 0, 1);

    // Branch in EX during a memory wait resolves only when memory completes
    br = mk(K_BR, 0, 1, 2, 1, 0);
    cyc(mk(K_ST, 3, 1, 2, 2, 0), 0, 0, 1);
    repeat (2) cyc(br, 0, 0, 0);
    cyc(br, 0, 0, 1);
    cyc(nop, 0, 0, 1);

    // x0 as destination never forwards nor stalls
    cyc(mk(K_R, 0, 1, 2, 0, 0), 0, 0, 1);
    cyc(mk(K_R, 3, 0, 0, 0, 0), 0, 0, 1);
    cyc(mk(K_LD, 0, 1, 0, 2, 0), 0, 0, 1);
    cyc(mk(K_R, 3, 0, 1, 0, 0), 0, 0, 1);

    // Randomised traffic over a small register set to provoke hazards
    for (int n = 0; n < 400; n++)
      cyc(mk_rand(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) != 0));

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
